// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding and default geometry for the memory arbiter
package mem_arb_pkg;
  localparam int AW_DEF = 6;
  localparam int DW_DEF = 64;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: two-request picker; req_a wins conflicts unless prefer_b is set
module arb_pick (
  input  logic req_a,
  input  logic req_b,
  input  logic conflict,
  input  logic prefer_b,
  output logic gnt_a,
  output logic gnt_b
);
  assign gnt_a = req_a & ~(conflict & prefer_b);
  assign gnt_b = req_b & ~(conflict & ~prefer_b);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data port arbiter onto one single-cycle-latency memory
// ARB_ROUND_ROBIN_EN selects alternating conflict winner; default is data-port priority
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);
  logic          if_req_v, d_req_v, conflict, prefer_if;
  owner_e        owner_q, owner_d;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  assign if_req_v = if_req & ~reset;
  assign d_req_v  = d_req & ~reset;
  assign conflict = if_req_v & d_req_v;
  arb_pick u_pick (
    .req_a    (d_req_v),
    .req_b    (if_req_v),
    .conflict (conflict),
    .prefer_b (prefer_if),
    .gnt_a    (d_gnt),
    .gnt_b    (if_gnt)
  );
`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;
  always_ff @(posedge clk) begin
    if (reset) last_d_q <= 1'b0;
    else if (conflict) last_d_q <= d_gnt;
  end
  assign prefer_if = last_d_q;
`else
  assign prefer_if = 1'b0;
`endif
  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : if_gnt ? if_addr : '0;
  assign mem_wdata = mem_we ? d_wdata : '0;
  assign stall     = (if_req_v & ~if_gnt) | (d_req_v & ~d_gnt);
  assign owner_d   = if_gnt ? OWN_IF : (d_gnt & ~d_we) ? OWN_D : OWN_NONE;
  // Owner is cleared by reset, so a read in flight at reset never returns
  assign if_rvalid = ~reset & (owner_q == OWN_IF);
  assign d_rvalid  = ~reset & (owner_q == OWN_D);
  assign if_rdata  = reset ? '0 : if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = reset ? '0 : d_rvalid ? mem_rdata : d_rdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q <= owner_d;
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench with a behavioural 64-word memory
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 64;
  logic          clk = 1'b0, reset = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [64];
  int vecs = 0, errs = 0;
  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] img(input int i);
    return (i == 5) ? 64'hF8000001 : {32'hC0DE0000, 32'(i * 3 + 1)};
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= img(i);
    end else begin
      if (mem_en & mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en & ~mem_we) mem_rdata <= mem[mem_addr];
    end
  end
  task automatic drive(input logic r, input logic ir, input logic [5:0] ia,
                       input logic dr, input logic dw, input logic [5:0] da, input logic [63:0] dwd);
    @(negedge clk);
    reset = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    int gcount;
    logic exp_d, prev_d;
    drive(1, 1, 6'd1, 1, 1, 6'd2, 64'h55);
    drive(1, 1, 6'd1, 1, 1, 6'd2, 64'h55);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    drive(0, 1, 6'd5, 0, 0, 6'd0, 0);
    chk("fetch_gnt", if_gnt, 1);
    chk("fetch_mem_en", mem_en, 1);
    chk("fetch_addr", mem_addr, 5);
    chk("fetch_stall", stall, 0);
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 64'hF8000001);
    chk("fetch_d_rvalid", d_rvalid, 0);
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("fetch_pulse", if_rvalid, 0);
    chk("fetch_hold", if_rdata, 64'hF8000001);
    gcount = 0;
    for (int k = 0; k < 64; k++) begin
      drive(0, 1, 6'(k), 0, 0, 6'd0, 0);
      gcount += int'(if_gnt);
      chk("seq_addr", mem_addr, 64'(k));
      if (k > 0) begin
        chk("seq_rvalid", if_rvalid, 1);
        chk("seq_rdata", if_rdata, img(k - 1));
      end
    end
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("seq_last_rvalid", if_rvalid, 1);
    chk("seq_last_rdata", if_rdata, img(63));
    chk("seq_grants", 64'(gcount), 64);
    drive(0, 0, 6'd0, 1, 1, 6'd3, 64'hA5);
    chk("st_gnt", d_gnt, 1);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 64'hA5);
    drive(0, 0, 6'd0, 1, 0, 6'd3, 0);
    chk("st_no_rvalid", d_rvalid, 0);
    chk("ld_gnt", d_gnt, 1);
    chk("ld_we", mem_we, 0);
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("ld_rvalid", d_rvalid, 1);
    chk("ld_rdata", d_rdata, 64'hA5);
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("ld_pulse", d_rvalid, 0);
    chk("ld_hold", d_rdata, 64'hA5);
    prev_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 6'd10, 1, 0, 6'd20, 0);
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk("cf_d_gnt", d_gnt, exp_d);
      chk("cf_if_gnt", if_gnt, !exp_d);
      chk("cf_stall", stall, 1);
      if (i > 0) begin
        chk("cf_d_rvalid", d_rvalid, prev_d);
        chk("cf_if_rvalid", if_rvalid, !prev_d);
        chk("cf_rdata", prev_d ? d_rdata : if_rdata, prev_d ? img(20) : img(10));
      end
      prev_d = exp_d;
    end
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("cf_last_rvalid", {d_rvalid, if_rvalid}, prev_d ? 64'd2 : 64'd1);
    drive(0, 1, 6'd7, 0, 0, 6'd0, 0);
    chk("mr_gnt", if_gnt, 1);
    drive(1, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("mr_rvalid_in", {if_rvalid, d_rvalid}, 0);
    chk("mr_mem_en", mem_en, 0);
    chk("mr_rdata", if_rdata, 0);
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("mr_rvalid_after", {if_rvalid, d_rvalid}, 0);
    drive(0, 1, 6'd9, 1, 0, 6'd4, 0);
    chk("wd_d_gnt", d_gnt, 1);
    chk("wd_if_gnt", if_gnt, 0);
    chk("wd_stall", stall, 1);
    drive(0, 0, 6'd9, 0, 0, 6'd0, 0);
    chk("wd_mem_en", mem_en, 0);
    chk("wd_stall_off", stall, 0);
    chk("wd_d_rdata", d_rdata, img(4));
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("wd_no_if_rvalid", if_rvalid, 0);
    drive(0, 0, 6'd0, 1, 1, 6'd63, 64'hDEADBEEF00000063);
    chk("wrap_addr", mem_addr, 63);
    chk("wrap_we", mem_we, 1);
    drive(0, 0, 6'd0, 1, 0, 6'd63, 0);
    chk("wrap_ld_gnt", d_gnt, 1);
    drive(0, 0, 6'd0, 0, 0, 6'd0, 0);
    chk("wrap_rvalid", d_rvalid, 1);
    chk("wrap_rdata", d_rdata, 64'hDEADBEEF00000063);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 6, memory word-address width (64-entry memory).
REQ-002 Parameter DW, default 64, memory data width in bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch read request; held until granted.
REQ-006 if_addr  in  AW  fetch word address; stable while if_req high.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch read data valid.
REQ-009 if_rdata  out  DW  fetch read data.
REQ-010 d_req  in  1  data-port request (load or store); held until granted.
REQ-011 d_we  in  1  1 = store, 0 = load; stable while d_req high.
REQ-012 d_addr  in  AW  data word address.
REQ-013 d_wdata  in  DW  store data.
REQ-014 d_gnt  out  1  data request accepted this cycle.
REQ-015 d_rvalid  out  1  load data valid; never asserted for stores.
REQ-016 d_rdata  out  DW  load data.
REQ-017 mem_en  out  1  memory access this cycle.
REQ-018 mem_we  out  1  memory write strobe.
REQ-019 mem_addr  out  AW  memory address.
REQ-020 mem_wdata  out  DW  memory write data.
REQ-021 mem_rdata  in  DW  memory read data, valid exactly one cycle after mem_en with mem_we=0.
REQ-022 stall  out  1  high while any request is pending and not granted (processor stall).

Function
REQ-023 At most one grant per cycle; grant is combinational in the cycle the request is presented.
REQ-024 mem_en = if_gnt | d_gnt; mem_addr/mem_we/mem_wdata driven from the granted requester; mem_we = d_gnt & d_we.
REQ-025 Read latency exactly 1 cycle: if_rvalid (or d_rvalid) asserts the cycle after the corresponding read grant, with x_rdata = mem_rdata; single-cycle pulse.
REQ-026 A registered owner flag (NONE/IF/D) records the previous cycle's read grant and routes mem_rdata; owner NONE after a store or idle cycle.
REQ-027 x_rdata holds its last value when x_rvalid is low.
REQ-028 Back-to-back grants allowed every cycle (full throughput); a grant issued while a previous read returns is legal.
REQ-029 Simultaneous if_req and d_req: arbitration per REQ-033/REQ-034; loser sees x_gnt=0 and stall=1.
REQ-030 Only one requester active: granted immediately regardless of priority state.
REQ-031 Address wrap: AW-bit addresses used verbatim, no bounds check; address 2^AW-1 legal.
REQ-032 Dropping x_req before grant withdraws the request with no memory side effect.

Configuration
REQ-033 With ARB_ROUND_ROBIN_EN defined: a 1-bit last-winner register; on conflict the port that did not win last conflict is granted; register updates only on conflict cycles; reset value favours data port first.
REQ-034 Without ARB_ROUND_ROBIN_EN: fixed priority, data port always wins conflicts; last-winner register absent.

Reset
REQ-035 While reset high: if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, stall = 0; owner = NONE; if_rdata, d_rdata, mem_addr, mem_wdata = 0; requests ignored.
REQ-036 Reset asserted mid-operation discards an in-flight read: no rvalid in the cycle after reset deasserts.

Structure
REQ-037 Shared package mem_arb_pkg holds owner enum (OWN_NONE, OWN_IF, OWN_D) and AW/DW default constants.
REQ-038 One sub-module arb_pick (two-request priority picker, conflict/last-winner inputs) is natural; rest flat.

Verification
REQ-039 if_req=1, if_addr=5, mem[5]=64'hF8000001 -> if_gnt same cycle, if_rvalid next cycle, if_rdata=64'hF8000001.
REQ-040 d_req=1, d_we=1, d_addr=3, d_wdata=64'hA5, then load addr 3 -> store: mem_we=1, no d_rvalid; load: d_rdata=64'hA5 one cycle after grant.
REQ-041 if_req and d_req both held 4 cycles, no macro -> d_gnt every cycle, stall=1, if_gnt=0 throughout.
REQ-042 Same stimulus with ARB_ROUND_ROBIN_EN -> grants alternate D, IF, D, IF; rvalids alternate one cycle later.
REQ-043 Read granted, reset asserted next cycle for 1 cycle -> if_rvalid/d_rvalid stay 0 during and after reset.
REQ-044 Fetch addresses 0..63 sequentially, one per cycle -> 64 grants in 64 cycles, data matches preloaded image, address 63 returned correctly.
